sbox_scheduler: RTL and testbench

SBOX_SCHEDULER -- requirements
Module: sbox_scheduler

---
 rtl/sbox_scheduler.sv | 164 ++++++++++++++++
 tb/tb_sbox_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_scheduler.sv
// Four shared AES S-box lanes time-multiplexed between a 128-bit state
// requester (four passes) and a 32-bit key-word requester (one pass).

module sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as required
    always_comb begin
        sq  = a_i;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module sbox_scheduler #(
    parameter int KEY_PRIORITY = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_in_valid,
    output logic         st_in_ready,
    input  logic [127:0] st_in_data,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         kw_in_valid,
    output logic         kw_in_ready,
    input  logic [31:0]  kw_in_data,
    output logic         kw_out_valid,
    input  logic         kw_out_ready,
    output logic [31:0]  kw_out_data
);
    typedef enum logic [1:0] {IDLE, ST_BUSY, KW_BUSY} state_t;

    state_t       state_q, state_d;
    logic [1:0]   pass_q, pass_d;
    logic [127:0] st_buf_q, st_buf_d;
    logic [127:0] st_data_q, st_data_d;
    logic         st_vld_q, st_vld_d;
    logic [31:0]  kw_buf_q, kw_buf_d;
    logic [31:0]  kw_data_q, kw_data_d;
    logic         kw_vld_q, kw_vld_d;
    logic         last_kw_q, last_kw_d;

    logic [7:0]   lane_in  [4];
    logic [7:0]   lane_out [4];
    logic         st_elig, kw_elig, st_grant, kw_grant;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        sbox u_sbox (.a_i(lane_in[k]), .y_o(lane_out[k]));
    end

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (state_q == KW_BUSY) lane_in[k] = kw_buf_q[{2'(k), 3'b000} +: 8];
            else                    lane_in[k] = st_buf_q[{pass_q, 2'(k), 3'b000} +: 8];
        end
    end

    // eligibility looks at registered out_valid, so a draining output never re-arms in the same cycle
    always_comb begin
        st_elig  = (state_q == IDLE) && st_in_valid && !st_vld_q && !rst;
        kw_elig  = (state_q == IDLE) && kw_in_valid && !kw_vld_q && !rst;
        st_grant = st_elig && (!kw_elig || (KEY_PRIORITY == 0 && last_kw_q));
        kw_grant = kw_elig && !st_grant;
    end

    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        st_buf_d  = st_buf_q;
        st_data_d = st_data_q;
        st_vld_d  = st_vld_q;
        kw_buf_d  = kw_buf_q;
        kw_data_d = kw_data_q;
        kw_vld_d  = kw_vld_q;
        last_kw_d = last_kw_q;

        if (st_vld_q && st_out_ready) st_vld_d = 1'b0;
        if (kw_vld_q && kw_out_ready) kw_vld_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (st_grant) begin
                    st_buf_d  = st_in_data;
                    pass_d    = '0;
                    state_d   = ST_BUSY;
                    last_kw_d = 1'b0;
                end else if (kw_grant) begin
                    kw_buf_d  = kw_in_data;
                    state_d   = KW_BUSY;
                    last_kw_d = 1'b1;
                end
            end
            ST_BUSY: begin
                for (int unsigned k = 0; k < 4; k++)
                    st_data_d[{pass_q, 2'(k), 3'b000} +: 8] = lane_out[k];
                pass_d = pass_q + 2'd1;
                if (pass_q == 2'd3) begin
                    st_vld_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            KW_BUSY: begin
                kw_data_d = {lane_out[3], lane_out[2], lane_out[1], lane_out[0]};
                kw_vld_d  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pass_q    <= '0;
            st_buf_q  <= '0;
            st_data_q <= '0;
            st_vld_q  <= 1'b0;
            kw_buf_q  <= '0;
            kw_data_q <= '0;
            kw_vld_q  <= 1'b0;
            last_kw_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            st_buf_q  <= st_buf_d;
            st_data_q <= st_data_d;
            st_vld_q  <= st_vld_d;
            kw_buf_q  <= kw_buf_d;
            kw_data_q <= kw_data_d;
            kw_vld_q  <= kw_vld_d;
            last_kw_q <= last_kw_d;
        end
    end

    assign st_in_ready  = st_grant;
    assign kw_in_ready  = kw_grant;
    assign st_out_valid = st_vld_q;
    assign st_out_data  = st_data_q;
    assign kw_out_valid = kw_vld_q;
    assign kw_out_data  = kw_data_q;
endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed bench for sbox_scheduler: one round-robin instance and one key-priority instance.

module tb_sbox_scheduler;
    logic         clk = 1'b0;
    logic         rst;

    logic         st_in_valid, st_in_ready, st_out_valid, st_out_ready;
    logic [127:0] st_in_data, st_out_data;
    logic         kw_in_valid, kw_in_ready, kw_out_valid, kw_out_ready;
    logic [31:0]  kw_in_data, kw_out_data;

    logic         k_st_in_valid, k_st_in_ready, k_st_out_valid, k_st_out_ready;
    logic [127:0] k_st_in_data, k_st_out_data;
    logic         k_kw_in_valid, k_kw_in_ready, k_kw_out_valid, k_kw_out_ready;
    logic [31:0]  k_kw_in_data, k_kw_out_data;

    int unsigned  checks = 0;
    int unsigned  failures = 0;
    int unsigned  g_cyc [$];
    bit           g_kw  [$];

    localparam logic [127:0] ALL63   = {16{8'h63}};
    localparam logic [127:0] SEQ_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] SEQ_OUT = 128'h76abd7fe2b670130c56f6bf27b777c63;

    always #5 clk = ~clk;

    sbox_scheduler #(.KEY_PRIORITY(0)) dut (
        .clk(clk), .rst(rst),
        .st_in_valid(st_in_valid), .st_in_ready(st_in_ready), .st_in_data(st_in_data),
        .st_out_valid(st_out_valid), .st_out_ready(st_out_ready), .st_out_data(st_out_data),
        .kw_in_valid(kw_in_valid), .kw_in_ready(kw_in_ready), .kw_in_data(kw_in_data),
        .kw_out_valid(kw_out_valid), .kw_out_ready(kw_out_ready), .kw_out_data(kw_out_data)
    );

    sbox_scheduler #(.KEY_PRIORITY(1)) dut_kp (
        .clk(clk), .rst(rst),
        .st_in_valid(k_st_in_valid), .st_in_ready(k_st_in_ready), .st_in_data(k_st_in_data),
        .st_out_valid(k_st_out_valid), .st_out_ready(k_st_out_ready), .st_out_data(k_st_out_data),
        .kw_in_valid(k_kw_in_valid), .kw_in_ready(k_kw_in_ready), .kw_in_data(k_kw_in_data),
        .kw_out_valid(k_kw_out_valid), .kw_out_ready(k_kw_out_ready), .kw_out_data(k_kw_out_data)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold both requests valid with ready consumers and log every grant cycle.
    task automatic run_grants(input bit sel, input int unsigned ncyc);
        bit sr, kr;
        g_cyc.delete();
        g_kw.delete();
        if (sel) begin
            k_st_in_valid = 1'b1; k_kw_in_valid = 1'b1;
            k_st_out_ready = 1'b1; k_kw_out_ready = 1'b1;
        end else begin
            st_in_valid = 1'b1; kw_in_valid = 1'b1;
            st_out_ready = 1'b1; kw_out_ready = 1'b1;
        end
        for (int unsigned c = 0; c < ncyc; c++) begin
            #1;
            sr = sel ? k_st_in_ready : st_in_ready;
            kr = sel ? k_kw_in_ready : kw_in_ready;
            check("no_dual_ready", 128'(sr & kr), 128'd0);
            if (sr || kr) begin
                g_cyc.push_back(c);
                g_kw.push_back(kr);
            end
            tick();
        end
        if (sel) begin
            k_st_in_valid = 1'b0; k_kw_in_valid = 1'b0;
        end else begin
            st_in_valid = 1'b0; kw_in_valid = 1'b0;
        end
        repeat (8) tick();
    endtask

    initial begin
        int unsigned exp_cyc [7];
        bit          exp_kw  [7];

        rst = 1'b1;
        st_in_valid = 1'b1; st_in_data = '0; st_out_ready = 1'b0;
        kw_in_valid = 1'b1; kw_in_data = '0; kw_out_ready = 1'b0;
        k_st_in_valid = 1'b0; k_st_in_data = SEQ_IN; k_st_out_ready = 1'b0;
        k_kw_in_valid = 1'b0; k_kw_in_data = 32'h53FF0100; k_kw_out_ready = 1'b0;
        tick();
        check("rst_st_in_ready", 128'(st_in_ready), 128'd0);
        check("rst_kw_in_ready", 128'(kw_in_ready), 128'd0);
        check("rst_st_out_valid", 128'(st_out_valid), 128'd0);
        check("rst_kw_out_valid", 128'(kw_out_valid), 128'd0);
        check("rst_st_out_data", st_out_data, 128'd0);
        check("rst_kw_out_data", 128'(kw_out_data), 128'd0);
        st_in_valid = 1'b0; kw_in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // all-zero state -> 0x63 in every byte, 4 clocks after acceptance
        st_in_valid = 1'b1; st_in_data = '0;
        #1;
        check("zero_st_in_ready", 128'(st_in_ready), 128'd1);
        check("zero_kw_in_ready", 128'(kw_in_ready), 128'd0);
        tick();
        st_in_valid = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check("zero_lat_early", 128'(st_out_valid), 128'd0);
        end
        tick();
        check("zero_lat_valid", 128'(st_out_valid), 128'd1);
        check("zero_data", st_out_data, ALL63);

        // st output stalled 10 clocks while a key word is served
        st_in_valid = 1'b1; st_in_data = 128'h1;
        kw_in_valid = 1'b1; kw_in_data = 32'h53FF0100; kw_out_ready = 1'b0;
        #1;
        check("stall_kw_in_ready", 128'(kw_in_ready), 128'd1);
        check("stall_st_in_ready0", 128'(st_in_ready), 128'd0);
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            if (i == 0) kw_in_valid = 1'b0;
            if (i == 1) begin
                check("kw_lat_valid", 128'(kw_out_valid), 128'd1);
                check("kw_data", 128'(kw_out_data), 128'hED167C63);
            end
            if (i == 2) begin
                check("kw_hold_valid", 128'(kw_out_valid), 128'd1);
                check("kw_hold_data", 128'(kw_out_data), 128'hED167C63);
                kw_out_ready = 1'b1;
            end
            if (i == 3) check("kw_cleared", 128'(kw_out_valid), 128'd0);
            #1;
            check("stall_st_in_ready", 128'(st_in_ready), 128'd0);
            check("stall_st_valid", 128'(st_out_valid), 128'd1);
            check("stall_st_data", st_out_data, ALL63);
        end
        st_in_valid = 1'b0; st_out_ready = 1'b1;
        tick();
        check("st_cleared", 128'(st_out_valid), 128'd0);

        // reset during pass 2 discards the operation
        st_in_valid = 1'b1; st_in_data = SEQ_IN;
        #1;
        check("rp_st_in_ready", 128'(st_in_ready), 128'd1);
        tick();
        st_in_valid = 1'b0;
        tick();
        tick();
        st_in_valid = 1'b1; kw_in_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("rp_st_valid", 128'(st_out_valid), 128'd0);
        check("rp_st_data", st_out_data, 128'd0);
        check("rp_st_in_ready", 128'(st_in_ready), 128'd0);
        check("rp_kw_in_ready", 128'(kw_in_ready), 128'd0);
        st_in_valid = 1'b0; kw_in_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            tick();
            check("rp_no_output", 128'(st_out_valid), 128'd0);
        end
        st_in_valid = 1'b1;
        #1;
        check("seq_st_in_ready", 128'(st_in_ready), 128'd1);
        tick();
        st_in_valid = 1'b0;
        repeat (3) begin
            tick();
            check("seq_lat_early", 128'(st_out_valid), 128'd0);
        end
        tick();
        check("seq_lat_valid", 128'(st_out_valid), 128'd1);
        check("seq_data", st_out_data, SEQ_OUT);
        repeat (2) tick();

        // round-robin arbitration from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_grants(1'b0, 22);
        exp_cyc = '{0, 5, 7, 12, 14, 19, 21};
        exp_kw  = '{0, 1, 0, 1, 0, 1, 0};
        check("rr_grant_count", 128'(g_cyc.size()), 128'd7);
        for (int unsigned j = 0; j < 7 && j < g_cyc.size(); j++) begin
            check("rr_grant_cycle", 128'(g_cyc[j]), 128'(exp_cyc[j]));
            check("rr_grant_who", 128'(g_kw[j]), 128'(exp_kw[j]));
        end

        // key-word priority instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_grants(1'b1, 22);
        exp_cyc = '{0, 2, 7, 9, 14, 16, 21};
        exp_kw  = '{1, 0, 1, 0, 1, 0, 1};
        check("kp_grant_count", 128'(g_cyc.size()), 128'd7);
        for (int unsigned j = 0; j < 7 && j < g_cyc.size(); j++) begin
            check("kp_grant_cycle", 128'(g_cyc[j]), 128'(exp_cyc[j]));
            check("kp_grant_who", 128'(g_kw[j]), 128'(exp_kw[j]));
        end
        check("kp_kw_data", 128'(k_kw_out_data), 128'hED167C63);
        check("kp_st_data", k_st_out_data, SEQ_OUT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
